// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter, receiver and baud generator.
//  - OVERSAMPLE : baud ticks per bit period (16x oversampling)
//  - uart_state_e : serializer state encoding (3 bits)
//  - tick_cnt_w / bit_cnt_w : counter width helpers
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Tick counter must cover both one bit period and the stop period.
  function automatic int unsigned tick_cnt_w(input int unsigned stop_ticks);
    int unsigned w;
    w = $clog2(stop_ticks);
    return (w < 4) ? 4 : w;
  endfunction

  // Bit index counter; kept at least one bit wide for single-bit frames.
  function automatic int unsigned bit_cnt_w(input int unsigned nb_data);
    int unsigned w;
    w = $clog2(nb_data);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_mod.sv
// uart_tx_mod: UART serializer driven by a 16x oversampling baud tick.
//  Frame: start bit (0), NB_DATA data bits LSB first, optional parity bit,
//  stop period of STOP_TICKS ticks (1). Idle line is high.
//  Optional feature: define TX_PARITY_EN to insert a parity bit after the data
//  (even parity when PAR_ODD=0, odd when PAR_ODD=1).
// Ports:
//  i_clk          system clock, rising edge
//  i_reset        asynchronous active-high reset
//  i_s_tick       baud tick, one-clock pulse, 16 per bit
//  i_tx_start     start request, sampled only while idle
//  i_tx_data      frame payload, latched when the start is accepted
//  o_tx_done_tick one-clock pulse when the stop period ends
//  o_tx           serial line, registered
module uart_tx_mod
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned STOP_TICKS = 16,
  parameter int unsigned PAR_ODD    = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx_done_tick,
  output logic               o_tx
);

  localparam int unsigned TW = tick_cnt_w(STOP_TICKS);
  localparam int unsigned NW = bit_cnt_w(NB_DATA);

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(NB_DATA - 1);

  // Reject parameter values the frame logic cannot represent.
  if (STOP_TICKS < 1 || PAR_ODD > 1) begin : g_param_chk
    $error("uart_tx_mod: STOP_TICKS must be >= 1 and PAR_ODD must be 0 or 1");
  end

  uart_state_e        state_q, state_d;
  logic [TW-1:0]      s_q, s_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
`ifdef TX_PARITY_EN
  logic               par_q, par_d;
`endif

  // State register and datapath.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, counters and line level.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        // A tick in the accept cycle is deliberately not counted.
        if (i_tx_start) begin
          b_d     = i_tx_data;
          s_d     = '0;
          state_d = START;
`ifdef TX_PARITY_EN
          par_d   = (^i_tx_data) ^ 1'(PAR_ODD);
`endif
        end
      end

      START: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == DATA_LAST) begin
`ifdef TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

`ifdef TX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (i_s_tick) begin
          if (s_q == STOP_LAST) begin
            s_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase

    // Line level follows the upcoming state so the pin flop matches state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_mod.sv
// tb_uart_tx_mod: self-checking bench for uart_tx_mod with a frame-level
// reference model (segment levels indexed by ticks elapsed since accept).
module tb_uart_tx_mod;

  localparam int unsigned NB     = 8;
  localparam int unsigned STOP_T = 16;
  localparam int unsigned PODD   = 0;
`ifdef TX_PARITY_EN
  localparam int          PAR_SEGS = 1;
  localparam int          DONE_LIT = 176;
  localparam logic [15:0] SEG_MASK = 16'h07FF;
  localparam logic [15:0] LIT_AA = 16'h0554, LIT_00 = 16'h0400, LIT_FF = 16'h05FE;
  localparam logic [15:0] LIT_55 = 16'h04AA, LIT_3C = 16'h0478;
`else
  localparam int          PAR_SEGS = 0;
  localparam int          DONE_LIT = 160;
  localparam logic [15:0] SEG_MASK = 16'h03FF;
  localparam logic [15:0] LIT_AA = 16'h0354, LIT_00 = 16'h0200, LIT_FF = 16'h03FE;
  localparam logic [15:0] LIT_55 = 16'h02AA, LIT_3C = 16'h0278;
`endif
  localparam int TOTAL = 16 * (1 + NB + PAR_SEGS) + STOP_T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       done;
  logic       tx;

  uart_tx_mod #(.NB_DATA(NB), .STOP_TICKS(STOP_T), .PAR_ODD(PODD)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_s_tick       (tick),
    .i_tx_start     (start),
    .i_tx_data      (data),
    .o_tx_done_tick (done),
    .o_tx           (tx)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  bit rand_tick = 1'b0;
  bit chk_en    = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Line level for each 16-tick segment of a frame; everything past the
  // data/parity segments is stop (1).
  function automatic logic [15:0] frame_levels(input logic [7:0] d);
    logic [15:0] lv;
    lv = '1;
    lv[0] = 1'b0;
    for (int i = 0; i < NB; i++) lv[i+1] = d[i];
`ifdef TX_PARITY_EN
    lv[NB+1] = (^d) ^ 1'(PODD);
`endif
    return lv;
  endfunction

  // Reference model.
  logic        m_busy = 1'b0;
  logic        m_tx   = 1'b1;
  logic        m_done = 1'b0;
  int          m_ticks = 0;
  logic [15:0] m_seq = '1;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0;
      m_tx   = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy  = 1'b1;
          m_ticks = 0;
          m_seq   = frame_levels(data);
          m_tx    = 1'b0;
        end else begin
          m_tx = 1'b1;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == TOTAL) begin
          m_busy = 1'b0;
          m_tx   = 1'b1;
          m_done = 1'b1;
        end else begin
          m_tx = m_seq[m_ticks / 16];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("o_tx", tx, m_tx);
      check("o_tx_done_tick", done, m_done);
    end
    if (done) done_cnt++;
  end

  // One clock: inputs change 2 ns after the falling edge, sampling 1 ns after the rising edge.
  task automatic step(input logic st, input logic [7:0] d);
    @(negedge clk);
    #2;
    tick  = rand_tick ? ($urandom_range(0, 2) == 0) : ((cyc % 3) == 0);
    start = st;
    data  = d;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 start low during frame, 1 start held high, 2 random start pulses.
  task automatic send_frame(input logic [7:0] d, input int mode,
                            output int done_t, output logic [15:0] mids, output int first_tx);
    int   t;
    logic st;
    step(1'b1, d);
    first_tx = int'(tx);
    t = 0;
    done_t = -1;
    mids = '1;
    for (int c = 0; c < 4 * TOTAL + 20 && done_t < 0; c++) begin
      st = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(st, 8'($urandom));
      if (tick) t++;
      if (done) done_t = t;
      else if (tick && (t % 16) == 8) mids[t / 16] = tx;
    end
  endtask

  initial begin
    int          dt, ft, d0, t;
    logic [15:0] mids;
    bit          rst_pend;

    // Reset held for three clocks.
    repeat (3) step(1'b0, 8'h00);
    check("reset_tx", tx, 1);
    check("reset_done", done, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Idle with no start request.
    repeat (10) step(1'b0, 8'hAA);
    check("idle_tx", tx, 1);

    // Single frame 0xAA.
    d0 = done_cnt;
    send_frame(8'hAA, 0, dt, mids, ft);
    check("aa_start_bit", ft, 0);
    check("aa_done_tick", dt, DONE_LIT);
    check("aa_bits", mids & SEG_MASK, LIT_AA);
    step(1'b0, 8'h00);
    check("aa_tx_after", tx, 1);
    check("aa_done_count", done_cnt - d0, 1);

    // Back-to-back 0x00 then 0xFF with start held.
    d0 = done_cnt;
    send_frame(8'h00, 1, dt, mids, ft);
    check("b2b0_done_tick", dt, DONE_LIT);
    check("b2b0_bits", mids & SEG_MASK, LIT_00);
    send_frame(8'hFF, 1, dt, mids, ft);
    check("b2b_restart_gap", ft, 0);
    check("b2b1_done_tick", dt, DONE_LIT);
    check("b2b1_bits", mids & SEG_MASK, LIT_FF);
    repeat (5) step(1'b0, 8'h00);
    check("b2b_done_count", done_cnt - d0, 2);

    // Start pulses and new data mid-frame are ignored.
    d0 = done_cnt;
    send_frame(8'h3C, 2, dt, mids, ft);
    check("mid_done_tick", dt, DONE_LIT);
    check("mid_bits", mids & SEG_MASK, LIT_3C);
    repeat (3) step(1'b0, 8'h00);
    check("mid_done_count", done_cnt - d0, 1);

    // Reset during data bit 3 of 0x55.
    step(1'b1, 8'h55);
    t = 0;
    for (int c = 0; c < 1000 && t < 16 * 4 + 5; c++) begin
      step(1'b0, 8'($urandom));
      if (tick) t++;
    end
    check("bit3_level", tx, 0);
    d0 = done_cnt;
    @(negedge clk);
    #5 rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_done", done, 0);
    repeat (2) step(1'b0, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) step(1'b0, 8'h00);
    check("abort_no_done", done_cnt - d0, 0);
    send_frame(8'h55, 0, dt, mids, ft);
    check("post_abort_done_tick", dt, DONE_LIT);
    check("post_abort_bits", mids & SEG_MASK, LIT_55);
    step(1'b0, 8'h00);

`ifdef TX_PARITY_EN
    send_frame(8'h07, 0, dt, mids, ft);
    check("par07_done_tick", dt, 176);
    check("par07_bits", mids & SEG_MASK, 16'h060E);
    step(1'b0, 8'h00);
`endif

    // Irregular tick spacing on a known frame.
    rand_tick = 1'b1;
    send_frame(8'hAA, 0, dt, mids, ft);
    check("rt_aa_done_tick", dt, DONE_LIT);
    check("rt_aa_bits", mids & SEG_MASK, LIT_AA);

    // Random traffic with occasional resets; checked cycle by cycle.
    rst_pend = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      step($urandom_range(0, 15) == 0, 8'($urandom));
      if (rst_pend) begin
        rst = 1'b0;
        rst_pend = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        rst_pend = 1'b1;
      end
    end
    rst = 1'b0;
    repeat (2) step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
